// File: rtl/clk_div_multi.sv
// Multi-channel programmable 50%-duty clock divider with tick strobes and a
// single-slot valid/ready divisor reload port. Optional sync input: CLKDIV_SYNC_EN.
module clk_div_multi #(
   parameter int CH          = 4,
   parameter int WIDTH       = 32,
   parameter int DEFAULT_DIV = 5000
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [CH-1:0]                        en,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
   input  logic [WIDTH-1:0]                     cfg_div,
   output logic                                 cfg_err,
   output logic [CH-1:0]                        clk_out,
   output logic [CH-1:0]                        tick
`ifdef CLKDIV_SYNC_EN
   ,
   input  logic                                 sync
`endif
);

   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic [WIDTH-1:0] hp  [CH];
   logic [WIDTH-1:0] cnt [CH];
   logic             pend_valid;
   logic [CHW-1:0]   pend_ch;
   logic [WIDTH-1:0] pend_div;

   logic [CH-1:0]    wrap;
   logic [CH-1:0]    apply;
   logic             sync_i;
   logic             accept;
   logic             bad_req;

`ifdef CLKDIV_SYNC_EN
   assign sync_i = sync;
`else
   assign sync_i = 1'b0;
`endif

   assign cfg_ready = ~pend_valid;
   assign accept    = cfg_valid && !pend_valid;
   assign bad_req   = (cfg_div == '0) || (int'(cfg_ch) >= CH);

   // A pending reload lands on the target's wrap (old hp still used for that
   // wrap) or immediately while the channel is idle; sync holds it back.
   always_comb begin
      wrap  = '0;
      apply = '0;
      for (int i = 0; i < CH; i++) begin
         wrap[i]  = en[i] && !sync_i && (cnt[i] == hp[i] - WIDTH'(1));
         apply[i] = pend_valid && (pend_ch == CHW'(i)) && !sync_i
                    && (wrap[i] || !en[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid <= 1'b0;
         cfg_err    <= 1'b0;
         clk_out    <= '0;
         tick       <= '0;
         for (int i = 0; i < CH; i++) begin
            hp[i]  <= WIDTH'(DEFAULT_DIV);
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (apply[i])
               hp[i] <= pend_div;
            if (sync_i || !en[i]) begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
            end else if (wrap[i]) begin
               cnt[i]     <= '0;
               clk_out[i] <= ~clk_out[i];
               tick[i]    <= 1'b1;
            end else begin
               cnt[i]     <= cnt[i] + WIDTH'(1);
               tick[i]    <= 1'b0;
            end
         end
         cfg_err <= accept && bad_req;
         if (accept && !bad_req)
            pend_valid <= 1'b1;
         else if (|apply)
            pend_valid <= 1'b0;
      end
   end

   // Slot payload is only meaningful while pend_valid is set.
   always_ff @(posedge clk) begin
      if (accept && !bad_req) begin
         pend_ch  <= cfg_ch;
         pend_div <= cfg_div;
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: deadline-based reference model plus directed
// scenarios with hand-computed checkpoints.
module tb_clk_div_multi;

   localparam int CH  = 3;
   localparam int W   = 16;
   localparam int DEF = 4;
   localparam int CHW = 2;

   logic           clk;
   logic           reset;
   logic [CH-1:0]  en;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [W-1:0]   cfg_div;
   logic           cfg_err;
   logic [CH-1:0]  clk_out;
   logic [CH-1:0]  tick;
   logic           sync;

   clk_div_multi #(.CH(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick)
`ifdef CLKDIV_SYNC_EN
      ,
      .sync      (sync)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each channel keeps the absolute edge number of its next
   // toggle; the reload slot is a simple flag plus payload.
   int            t = 0;
   bit            started = 0;
   int            m_hp  [CH];
   int            m_due [CH];
   logic [CH-1:0] m_lvl = '0;
   logic [CH-1:0] m_tick = '0;
   bit            m_pend = 0;
   int            m_pch = 0;
   int            m_pdiv = 0;
   bit            m_err = 0;

   always @(posedge clk) begin : model
      bit acc, s, wr, app, freed;
      t++;
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            m_hp[i]  = DEF;
            m_due[i] = t + DEF;
         end
         m_lvl   = '0;
         m_tick  = '0;
         m_pend  = 0;
         m_err   = 0;
         started = 1;
      end else begin
         acc = cfg_valid && !m_pend;
`ifdef CLKDIV_SYNC_EN
         s = sync;
`else
         s = 0;
`endif
         freed = 0;
         for (int i = 0; i < CH; i++) begin
            wr  = en[i] && !s && (t == m_due[i]);
            app = m_pend && (m_pch == i) && !s && (wr || !en[i]);
            if (app) begin
               m_hp[i] = m_pdiv;
               freed   = 1;
            end
            if (s || !en[i]) begin
               m_lvl[i]  = 1'b0;
               m_tick[i] = 1'b0;
               m_due[i]  = t + m_hp[i];
            end else if (wr) begin
               m_lvl[i]  = ~m_lvl[i];
               m_tick[i] = 1'b1;
               m_due[i]  = t + m_hp[i];
            end else begin
               m_tick[i] = 1'b0;
            end
         end
         m_err = acc && (cfg_div == 0 || int'(cfg_ch) >= CH);
         if (freed) m_pend = 0;
         if (acc && !m_err) begin
            m_pend = 1;
            m_pch  = int'(cfg_ch);
            m_pdiv = int'(cfg_div);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("clk_out", clk_out, m_lvl);
         check("tick", tick, m_tick);
         check("cfg_ready", cfg_ready, !m_pend);
         check("cfg_err", cfg_err, m_err);
      end
   end

   task automatic cfg_write(input int ch, input int div);
      bit ok, r;
      cfg_valid = 1'b1;
      cfg_ch    = CHW'(ch);
      cfg_div   = W'(div);
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
         r = cfg_ready;
         @(negedge clk);
         if (r) ok = 1;
      end
      cfg_valid = 1'b0;
      check("cfg_accept", ok, 1);
   endtask

   initial begin
      bit seen;
      reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_clk_out", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_err", cfg_err, 0);

      // First rise on the 4th edge after release, fall on the 8th.
      reset = 1'b0; en = '1;
      repeat (3) @(negedge clk);
      check("pre_rise", clk_out[0], 0);
      @(negedge clk);
      check("rise4", clk_out[0], 1);
      check("tick4", tick[0], 1);
      @(negedge clk);
      check("tick5", tick[0], 0);
      repeat (3) @(negedge clk);
      check("fall8", clk_out[0], 0);
      check("tick8", tick[0], 1);

      // Reload ch1 to 2 one cycle before its wrap.
      repeat (2) @(negedge clk);
      cfg_write(1, 2);
      check("reload_busy", cfg_ready, 0);
      @(negedge clk);
      check("reload_applied", cfg_ready, 1);
      check("reload_wrap", tick[1], 1);
      @(negedge clk);
      check("hp2_gap", tick[1], 0);
      @(negedge clk);
      check("hp2_tick", tick[1], 1);

      // Rejected requests.
      cfg_write(0, 0);
      check("err_div0", cfg_err, 1);
      @(negedge clk);
      check("err_div0_end", cfg_err, 0);
      cfg_write(3, 5);
      check("err_ch", cfg_err, 1);
      check("err_ch_ready", cfg_ready, 1);
      @(negedge clk);
      check("err_ch_end", cfg_err, 0);

      // Disable while high, re-enable, then reload while disabled.
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (clk_out[0]) seen = 1;
         else @(negedge clk);
      end
      check("wait_high", seen, 1);
      en[0] = 1'b0;
      @(negedge clk);
      check("dis_low", clk_out[0], 0);
      check("dis_tick", tick[0], 0);
      en[0] = 1'b1;
      repeat (3) @(negedge clk);
      check("reen_pre", clk_out[0], 0);
      @(negedge clk);
      check("reen_rise", clk_out[0], 1);
      en[0] = 1'b0;
      @(negedge clk);
      cfg_write(0, 6);
      check("dis_pend", cfg_ready, 0);
      @(negedge clk);
      check("dis_apply", cfg_ready, 1);
      en[0] = 1'b1;
      repeat (5) @(negedge clk);
      check("hp6_pre", clk_out[0], 0);
      @(negedge clk);
      check("hp6_rise", clk_out[0], 1);

      // Back-pressure: second request stalls until the first lands.
      cfg_write(2, 3);
      cfg_write(1, 5);
      check("bp_second_pend", cfg_ready, 0);
      repeat (10) @(negedge clk);

      // Reset while pending discards the update.
      cfg_write(2, 7);
      reset = 1'b1;
      @(negedge clk);
      check("rst_pend_ready", cfg_ready, 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pre_tick", tick, 0);
      @(negedge clk);
      check("rst_all_tick", tick, 3'b111);
      repeat (8) @(negedge clk);

      // HP=1: clk/2 with tick continuously high.
      cfg_write(1, 1);
      repeat (8) @(negedge clk);
      check("hp1_tick_a", tick[1], 1);
      @(negedge clk);
      check("hp1_tick_b", tick[1], 1);

`ifdef CLKDIV_SYNC_EN
      cfg_write(0, 3);
      repeat (6) @(negedge clk);
      cfg_write(1, 5);
      repeat (12) @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check("sync_low", clk_out, 0);
      repeat (2) @(negedge clk);
      check("sync_ch0_pre", clk_out[0], 0);
      @(negedge clk);
      check("sync_ch0_rise", clk_out[0], 1);
      @(negedge clk);
      check("sync_ch1_pre", clk_out[1], 0);
      @(negedge clk);
      check("sync_ch1_rise", clk_out[1], 1);
`endif

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
